// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg -- shared definitions for the common-data-bus arbiter.
//
// Contents:
//   CDB_BW_DATA / CDB_BW_TAG   default result and tag widths
//   CDB_DATA_MAX / CDB_TAG_MAX storage width of the entry fields (largest
//                              supported BW_DATA / BW_TAG)
//   CDB_SRC_MAX                storage width of the source index (up to 16 requesters)
//   cdb_entry_t                one broadcast entry: data, tag, spec, src
//
// Optional feature macro used by the arbiter: CDB_ARBITER_ROUND_ROBIN_EN.
package cdb_arbiter_pkg;

  localparam int CDB_BW_DATA  = 32;
  localparam int CDB_BW_TAG   = 4;
  localparam int CDB_DATA_MAX = 64;
  localparam int CDB_TAG_MAX  = 16;
  localparam int CDB_SRC_MAX  = 4;

  // Fields are sized to the largest supported configuration; the arbiter
  // zero-extends into them and slices its outputs back out.
  typedef struct packed {
    logic [CDB_DATA_MAX-1:0] data;
    logic [CDB_TAG_MAX-1:0]  tag;
    logic                    spec;
    logic [CDB_SRC_MAX-1:0]  src;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_picker.sv
// RoundRobinPicker -- rotate-and-pick grant selection.
//
// Scans the request vector starting at index ptr and wrapping from N-1 to 0;
// the first asserted request wins. With ptr tied to zero this degenerates to
// fixed lowest-index-first priority.
//
// Ports:
//   req    in  [N-1:0]   request vector
//   ptr    in  [IW-1:0]  index to start scanning at (must be < N)
//   grant  out [N-1:0]   one-hot grant, all zero when no request
//   idx    out [IW-1:0]  index of the granted request (0 when none)
//
// Used by cdb_arbiter (feature macro CDB_ARBITER_ROUND_ROBIN_EN selects
// whether the pointer rotates).
module RoundRobinPicker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;
  int   k;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      // Candidate position i steps after the pointer, wrapped into 0..N-1.
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- arbitrates N_REQ functional-unit results onto a single
// common data bus with one registered output slot.
//
// Feature macro: CDB_ARBITER_ROUND_ROBIN_EN
//   defined   : round-robin priority, pointer advances to winner+1 on accept
//   undefined : fixed priority (lowest index wins), no pointer register
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   i_valid  in   [N_REQ]          per-requester result valid
//   i_ready  out  [N_REQ]          per-requester accept (one-hot or zero)
//   i_data   in   [N_REQ*BW_DATA]  requester k at [k*BW_DATA +: BW_DATA]
//   i_tag    in   [N_REQ*BW_TAG]   requester k at [k*BW_TAG +: BW_TAG]
//   i_spec   in   [N_REQ]          result is speculative (post-branch)
//   i_flush  in   branch mispredict: drop speculative held entry, accept nothing
//   o_valid  out  broadcast valid
//   o_ready  in   broadcast consumers accept
//   o_data   out  [BW_DATA] broadcast result
//   o_tag    out  [BW_TAG]  broadcast producer tag
//   o_src    out  [$clog2(N_REQ)] winning requester index
//
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high. Valid never waits on ready; once raised, valid and payload hold
// until the transfer (the only exception is a flush dropping a speculative
// held entry). Inputs: requester k transfers when i_valid[k] && i_ready[k].
// Output: the slot transfers when o_valid && o_ready. The slot counts as free
// when empty or draining this cycle, so drain and reload overlap without a
// bubble.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BW_DATA = CDB_BW_DATA,
  parameter int BW_TAG  = CDB_BW_TAG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           i_valid,
  output logic [N_REQ-1:0]           i_ready,
  input  logic [N_REQ*BW_DATA-1:0]   i_data,
  input  logic [N_REQ*BW_TAG-1:0]    i_tag,
  input  logic [N_REQ-1:0]           i_spec,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [BW_DATA-1:0]         o_data,
  output logic [BW_TAG-1:0]          o_tag,
  output logic [$clog2(N_REQ)-1:0]   o_src
);

  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0] grant;
  logic [SRC_W-1:0] win_idx;
  logic [SRC_W-1:0] pick_ptr;
  logic             slot_free;
  logic             accept_en;
  logic             accept;
  logic             valid_q;
  cdb_entry_t       slot_q;
  cdb_entry_t       win_entry;

  // ---------------------------------------------------------------------------
  // Priority pointer
  // ---------------------------------------------------------------------------
`ifdef CDB_ARBITER_ROUND_ROBIN_EN
  logic [SRC_W-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      // Next scan starts just after the winner; N_REQ need not be a power of 2.
      ptr_q <= (win_idx == SRC_W'(N_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
    end
  end

  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  RoundRobinPicker #(
    .N  (N_REQ),
    .IW (SRC_W)
  ) u_picker (
    .req   (i_valid),
    .ptr   (pick_ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  // ---------------------------------------------------------------------------
  // Accept decision
  // ---------------------------------------------------------------------------
  assign slot_free = !valid_q || o_ready;
  // rst gates the accept so nothing is offered while reset is held.
  assign accept_en = slot_free && !i_flush && rst;
  assign i_ready   = grant & {N_REQ{accept_en}};
  assign accept    = |i_ready;

  // Only the winner's payload is muxed in; other requesters' data/tag are
  // never looked at.
  always_comb begin
    win_entry                   = '0;
    win_entry.data[BW_DATA-1:0] = i_data[int'(win_idx)*BW_DATA +: BW_DATA];
    win_entry.tag[BW_TAG-1:0]   = i_tag[int'(win_idx)*BW_TAG +: BW_TAG];
    win_entry.spec              = i_spec[win_idx];
    win_entry.src[SRC_W-1:0]    = win_idx;
  end

  // ---------------------------------------------------------------------------
  // Output slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else if (accept) begin
      // Covers both loading an empty slot and replacing a draining one.
      valid_q <= 1'b1;
      slot_q  <= win_entry;
    end else if (i_flush && valid_q && slot_q.spec) begin
      valid_q <= 1'b0;
    end else if (valid_q && o_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = slot_q.data[BW_DATA-1:0];
  assign o_tag   = slot_q.tag[BW_TAG-1:0];
  assign o_src   = slot_q.src[SRC_W-1:0];

  // Upper storage bits beyond the configured widths are always zero.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{slot_q.data, slot_q.tag, slot_q.src};

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter -- directed self-checking bench for cdb_arbiter
// (N_REQ=4, BW_DATA=32, BW_TAG=4). Expected values follow the build:
// round-robin when CDB_ARBITER_ROUND_ROBIN_EN is defined, fixed priority
// otherwise. Requester k presents data 32'hA000_0000|k and tag k+4.
module tb_cdb_arbiter;

`ifdef CDB_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   i_valid;
  logic [3:0]   i_ready;
  logic [127:0] i_data;
  logic [15:0]  i_tag;
  logic [3:0]   i_spec;
  logic         i_flush;
  logic         o_valid;
  logic         o_ready;
  logic [31:0]  o_data;
  logic [3:0]   o_tag;
  logic [1:0]   o_src;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .N_REQ   (4),
    .BW_DATA (32),
    .BW_TAG  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_tag   (i_tag),
    .i_spec  (i_spec),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_tag   (o_tag),
    .o_src   (o_src)
  );

  function automatic logic [31:0] exp_data(int k);
    return 32'hA000_0000 | 32'(k);
  endfunction

  function automatic logic [3:0] exp_tag(int k);
    return 4'(k + 4);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst     = 1'b0;
    i_valid = 4'b1111;
    o_ready = 1'b1;
    i_flush = 1'b0;
    i_spec  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      i_data[k*32 +: 32] = exp_data(k);
      i_tag[k*4 +: 4]    = exp_tag(k);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    n_vec++; if (i_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_i_ready: got %b want 0000", i_ready); end
    n_vec++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_o_data: got %h want 0", o_data); end
    n_vec++; if (o_tag !== 4'h0) begin n_fail++; $display("FAIL reset_o_tag: got %h want 0", o_tag); end
    n_vec++; if (o_src !== 2'd0) begin n_fail++; $display("FAIL reset_o_src: got %0d want 0", o_src); end
    @(negedge clk);
    rst = 1'b1;
    settle();
    n_vec++; if (i_ready !== 4'b0001) begin n_fail++; $display("FAIL release_i_ready: got %b want 0001", i_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL first_o_valid: got %b want 1", o_valid); end
    n_vec++; if (o_src !== 2'd0) begin n_fail++; $display("FAIL first_o_src: got %0d want 0", o_src); end
    n_vec++; if (o_data !== exp_data(0)) begin n_fail++; $display("FAIL first_o_data: got %h want %h", o_data, exp_data(0)); end
    n_vec++; if (o_tag !== exp_tag(0)) begin n_fail++; $display("FAIL first_o_tag: got %h want %h", o_tag, exp_tag(0)); end
  endtask

  // All requesters held valid with the bus always ready: one broadcast per cycle.
  task automatic test_fairness;
    logic [1:0] rr_src [4];
    logic [3:0] rr_rdy [4];
    logic [1:0] want_src;
    logic [3:0] want_rdy;
    rr_src[0] = 2'd1; rr_src[1] = 2'd2; rr_src[2] = 2'd3; rr_src[3] = 2'd0;
    rr_rdy[0] = 4'b0010; rr_rdy[1] = 4'b0100; rr_rdy[2] = 4'b1000; rr_rdy[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      want_src = RR ? rr_src[i] : 2'd0;
      want_rdy = RR ? rr_rdy[i] : 4'b0001;
      settle();
      n_vec++; if (i_ready !== want_rdy) begin n_fail++; $display("FAIL fair_i_ready[%0d]: got %b want %b", i, i_ready, want_rdy); end
      tick();
      n_vec++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL fair_o_valid[%0d]: got %b want 1", i, o_valid); end
      n_vec++; if (o_src !== want_src) begin n_fail++; $display("FAIL fair_o_src[%0d]: got %0d want %0d", i, o_src, want_src); end
      n_vec++; if (o_data !== exp_data(int'(want_src))) begin n_fail++; $display("FAIL fair_o_data[%0d]: got %h want %h", i, o_data, exp_data(int'(want_src))); end
    end
    i_valid = 4'b0000;
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL fair_drain_o_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_backpressure;
    logic [3:0] want_rdy;
    logic [1:0] want_src;
    o_ready = 1'b0;
    i_valid = 4'b0010;
    settle();
    n_vec++; if (i_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_load_i_ready: got %b want 0010", i_ready); end
    tick();
    n_vec++; if (o_tag !== 4'd5) begin n_fail++; $display("FAIL bp_load_o_tag: got %0d want 5", o_tag); end
    i_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_vec++; if (i_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_i_ready[%0d]: got %b want 0000", i, i_ready); end
      tick();
      n_vec++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_o_valid[%0d]: got %b want 1", i, o_valid); end
      n_vec++; if (o_tag !== 4'd5) begin n_fail++; $display("FAIL bp_stall_o_tag[%0d]: got %0d want 5", i, o_tag); end
      n_vec++; if (o_src !== 2'd1) begin n_fail++; $display("FAIL bp_stall_o_src[%0d]: got %0d want 1", i, o_src); end
      n_vec++; if (o_data !== exp_data(1)) begin n_fail++; $display("FAIL bp_stall_o_data[%0d]: got %h want %h", i, o_data, exp_data(1)); end
    end
    o_ready  = 1'b1;
    want_rdy = RR ? 4'b0100 : 4'b0001;
    want_src = RR ? 2'd2 : 2'd0;
    settle();
    n_vec++; if (i_ready !== want_rdy) begin n_fail++; $display("FAIL bp_release_i_ready: got %b want %b", i_ready, want_rdy); end
    tick();
    n_vec++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_o_valid: got %b want 1", o_valid); end
    n_vec++; if (o_src !== want_src) begin n_fail++; $display("FAIL bp_release_o_src: got %0d want %0d", o_src, want_src); end
    i_valid = 4'b0000;
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_o_valid: got %b want 0", o_valid); end
  endtask

  // Entered with the round-robin pointer at 3.
  task automatic test_wrap;
    logic [3:0] want_rdy;
    logic [1:0] want_src;
    o_ready = 1'b1;
    i_valid = 4'b0011;
    settle();
    n_vec++; if (i_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_i_ready: got %b want 0001", i_ready); end
    tick();
    n_vec++; if (o_src !== 2'd0) begin n_fail++; $display("FAIL wrap_o_src: got %0d want 0", o_src); end
    want_rdy = RR ? 4'b0010 : 4'b0001;
    want_src = RR ? 2'd1 : 2'd0;
    settle();
    n_vec++; if (i_ready !== want_rdy) begin n_fail++; $display("FAIL wrap_next_i_ready: got %b want %b", i_ready, want_rdy); end
    tick();
    n_vec++; if (o_src !== want_src) begin n_fail++; $display("FAIL wrap_next_o_src: got %0d want %0d", o_src, want_src); end
    i_valid = 4'b0000;
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain_o_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_flush;
    logic [3:0] want_rdy;
    logic [1:0] want_src;
    o_ready = 1'b0;
    i_valid = 4'b0001;
    i_spec  = 4'b0001;
    tick();
    n_vec++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL flush_spec_load: got %b want 1", o_valid); end
    i_flush = 1'b1;
    i_valid = 4'b1111;
    settle();
    n_vec++; if (i_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_spec_i_ready: got %b want 0000", i_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_spec_o_valid: got %b want 0", o_valid); end
    i_flush = 1'b0;
    i_spec  = 4'b0000;
    i_valid = 4'b0100;
    tick();
    n_vec++; if (o_src !== 2'd2) begin n_fail++; $display("FAIL flush_nonspec_load: got %0d want 2", o_src); end
    i_flush = 1'b1;
    i_valid = 4'b1111;
    settle();
    n_vec++; if (i_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_nonspec_i_ready: got %b want 0000", i_ready); end
    tick();
    n_vec++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL flush_nonspec_o_valid: got %b want 1", o_valid); end
    n_vec++; if (o_data !== exp_data(2)) begin n_fail++; $display("FAIL flush_nonspec_o_data: got %h want %h", o_data, exp_data(2)); end
    i_flush  = 1'b0;
    o_ready  = 1'b1;
    want_rdy = RR ? 4'b1000 : 4'b0001;
    want_src = RR ? 2'd3 : 2'd0;
    settle();
    n_vec++; if (i_ready !== want_rdy) begin n_fail++; $display("FAIL flush_after_i_ready: got %b want %b", i_ready, want_rdy); end
    tick();
    n_vec++; if (o_src !== want_src) begin n_fail++; $display("FAIL flush_after_o_src: got %0d want %0d", o_src, want_src); end
    i_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid;
    o_ready = 1'b0;
    i_valid = 4'b0010;
    tick();
    n_vec++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_load: got %b want 1", o_valid); end
    #2;
    rst = 1'b0;
    settle();
    n_vec++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_o_valid: got %b want 0", o_valid); end
    n_vec++; if (i_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_i_ready: got %b want 0000", i_ready); end
    n_vec++; if (o_tag !== 4'h0) begin n_fail++; $display("FAIL midrst_o_tag: got %h want 0", o_tag); end
    @(negedge clk);
    rst     = 1'b1;
    o_ready = 1'b1;
    i_valid = 4'b1111;
    settle();
    n_vec++; if (i_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_release_i_ready: got %b want 0001", i_ready); end
    tick();
    n_vec++; if (o_src !== 2'd0) begin n_fail++; $display("FAIL midrst_release_o_src: got %0d want 0", o_src); end
    i_valid = 4'b0000;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    i_data = '0;
    i_tag  = '0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
